drop_step_sched: RTL and testbench

Drop-step scheduler that consumes the one-cycle carry pulses from the 4-bit tick counter chain. It divides them by a level-dependent ratio into drop-step credits, and hands each credit to the game-state logic over a req/ack handshake. Credits are buffered in a small saturating counter, so a slow consumer never loses steps silently.

---
 rtl/drop_pkg.sv | 14 +
 rtl/drop_step_sched_if.sv | 24 ++
 rtl/drop_prescaler.sv | 33 +++
 rtl/drop_step_sched.sv | 81 ++++++++
 tb/tb_drop_step_sched.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/drop_pkg.sv
// Shared types, threshold constants and the threshold helper for the drop-step scheduler.
package drop_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam int TH_BASE = 16;
  localparam int TH_STEP = 2;

  // Ticks per credit; level 0 is slowest (16), level 7 fastest (2).
  function automatic logic [4:0] th(input int unsigned lvl);
    return 5'(TH_BASE - TH_STEP * int'(lvl));
  endfunction

endpackage

// File: rtl/drop_step_sched_if.sv
// Tick, level and step handshake bundle between the counter chain, the scheduler and the game-state logic.
interface drop_step_sched_if #(
  parameter int CREDIT_W = 2,
  parameter int LEVEL_W  = 3
);
  logic                tick_in;
  logic [LEVEL_W-1:0]  level;
  logic                pause;
  logic                fast_drop;
  logic                step_ack;
  logic                step_req;
  logic [CREDIT_W-1:0] pending;
  logic                overflow;

  modport master (
    input  tick_in, level, pause, fast_drop, step_ack,
    output step_req, pending, overflow
  );

  modport slave (
    output tick_in, level, pause, fast_drop, step_ack,
    input  step_req, pending, overflow
  );
endinterface

// File: rtl/drop_prescaler.sv
// Level-dependent tick divider; fire is a one-cycle pulse on the tick that completes a period.
module drop_prescaler
  import drop_pkg::*;
#(
  parameter int LEVEL_W = 3
) (
  input  logic               CP,
  input  logic               CR,
  input  logic               tick_in,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  output logic               fire
);

  logic [3:0] p;
  logic [4:0] th_lvl;
  logic       step;

  assign th_lvl = th(int'(level));
  assign step   = tick_in & ~pause;
  // >= rather than == so a level raised mid-period fires on the next tick.
  assign fire   = step & ({1'b0, p} >= (th_lvl - 5'd1));

  always_ff @(posedge CP) begin
    if (CR) begin
      p <= 4'd0;
    end else if (step) begin
      if (fire) p <= 4'd0;
      else      p <= p + 4'd1;
    end
  end

endmodule

// File: rtl/drop_step_sched.sv
// Drop-step scheduler: divides tick pulses into credits and offers each credit over req/ack.
// Optional feature macro: DROP_SCHED_FAST_EN (fast_drop makes every tick a credit).
module drop_step_sched
  import drop_pkg::*;
#(
  parameter int CREDIT_W = 2,
  parameter int LEVEL_W  = 3
) (
  input logic                CP,
  input logic                CR,
  drop_step_sched_if.master  bus
);

  localparam logic [CREDIT_W-1:0] PEND_MAX = '1;

  state_t              state, state_nxt;
  logic                pre_fire;
  logic                credit;
  logic                accept;
  logic [CREDIT_W-1:0] pending_r;
  logic                overflow_r;
  logic                step_req_r;

  drop_prescaler #(.LEVEL_W(LEVEL_W)) u_prescaler (
    .CP      (CP),
    .CR      (CR),
    .tick_in (bus.tick_in),
    .pause   (bus.pause),
    .level   (bus.level),
    .fire    (pre_fire)
  );

`ifdef DROP_SCHED_FAST_EN
  // OR, not add: a coincident prescaler fire never yields a second credit.
  assign credit = pre_fire | (bus.fast_drop & bus.tick_in & ~bus.pause);
`else
  logic unused_fast_drop;
  assign unused_fast_drop = bus.fast_drop;
  assign credit = pre_fire;
`endif

  assign accept = (state == REQ) & bus.step_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((pending_r != '0) && !bus.pause) state_nxt = REQ;
      REQ:     if (bus.step_ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // step_req is its own flop so the output never decodes combinationally.
  always_ff @(posedge CP) begin
    if (CR) begin
      state      <= IDLE;
      step_req_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_req_r <= (state_nxt == REQ);
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
    end else if (credit && !accept) begin
      if (pending_r == PEND_MAX) overflow_r <= 1'b1;
      else                       pending_r  <= pending_r + 1'b1;
    end else if (accept && !credit) begin
      pending_r <= pending_r - 1'b1;
    end
  end

  assign bus.step_req = step_req_r;
  assign bus.pending  = pending_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_drop_step_sched.sv
// Scoreboard bench for drop_step_sched: directed scenarios plus random stimulus against a behavioural model.
module tb_drop_step_sched;
  import drop_pkg::*;

  localparam int CREDIT_W = 2;
  localparam int LEVEL_W  = 3;
  localparam int PMAX     = (1 << CREDIT_W) - 1;

  logic CP = 1'b0;
  logic CR;

  drop_step_sched_if #(.CREDIT_W(CREDIT_W), .LEVEL_W(LEVEL_W)) bus ();

  drop_step_sched #(.CREDIT_W(CREDIT_W), .LEVEL_W(LEVEL_W)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus.master)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic                req;
    logic [CREDIT_W-1:0] pend;
    logic                ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: tick accumulator, credit count, sticky overflow, and offer/cooldown flags.
  int m_p, m_pend, m_ovf, m_offer, m_cool;

  task automatic cycle(input bit rst, input bit tick, input int lvl,
                       input bit pz, input bit fd, input bit ack);
    int   th_v, credit, accept, pend_new;
    exp_t e;
    CR            = rst;
    bus.tick_in   = tick;
    bus.level     = lvl[LEVEL_W-1:0];
    bus.pause     = pz;
    bus.fast_drop = fd;
    bus.step_ack  = ack;
    if (rst) begin
      m_p = 0; m_pend = 0; m_ovf = 0; m_offer = 0; m_cool = 0;
    end else begin
      credit = 0;
      if (tick && !pz) begin
        th_v = 16 - 2 * lvl;
        if (m_p >= th_v - 1) begin
          m_p = 0;
          credit = 1;
        end else begin
          m_p = m_p + 1;
        end
`ifdef DROP_SCHED_FAST_EN
        if (fd) credit = 1;
`endif
      end
      accept   = (m_offer != 0 && ack) ? 1 : 0;
      pend_new = m_pend + credit - accept;
      if (pend_new > PMAX) begin
        pend_new = PMAX;
        m_ovf    = 1;
      end
      if (m_offer != 0) begin
        if (ack) begin
          m_offer = 0;
          m_cool  = 1;
        end
      end else if (m_cool != 0) begin
        m_cool = 0;
      end else if (m_pend != 0 && !pz) begin
        m_offer = 1;
      end
      m_pend = pend_new;
    end
    e.req  = (m_offer != 0);
    e.pend = m_pend[CREDIT_W-1:0];
    e.ovf  = (m_ovf != 0);
    @(posedge CP);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge CP) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.step_req !== e.req || bus.pending !== e.pend || bus.overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL outputs t=%0t got req=%0b pend=%0d ovf=%0b, expected req=%0b pend=%0d ovf=%0b",
                 $time, bus.step_req, bus.pending, bus.overflow, e.req, e.pend, e.ovf);
      end
    end
  end

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n, input int lvl, input bit ack);
    for (int i = 0; i < n; i++) cycle(0, 0, lvl, 0, 0, ack);
  endtask

  initial begin
    do_reset();
    idle(2, 0, 0);

    // Level 0, ack tied high: one step after the 16th tick.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
    end
    idle(5, 0, 1);

    // Level 7 with no consumer: saturation and overflow, then drain with three acks.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 7, 0, 0, 0);
      cycle(0, 0, 7, 0, 0, 0);
    end
    idle(3, 7, 0);
    idle(12, 7, 1);

    // Level raised from 0 to 7 with p = 9.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 7, 0, 0, 0);
    idle(3, 7, 0);

    // Credit arriving on the same edge as an accepted ack.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 10 && m_offer == 0; i++) cycle(0, 0, 7, 0, 0, 0);
    cycle(0, 1, 7, 0, 0, 1);
    idle(5, 7, 0);
    idle(4, 7, 1);

    // Pause swallows ticks, then reset mid-handshake.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 1, 7, 1, 0, 0);
    idle(3, 7, 0);
    cycle(0, 1, 7, 0, 0, 0);
    cycle(0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 10 && m_offer == 0; i++) cycle(0, 0, 7, 0, 0, 0);
    cycle(1, 0, 7, 0, 0, 0);
    idle(3, 7, 0);

    // fast_drop at level 0: credits only when the feature is built in.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 0);
    idle(3, 0, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CP);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain %0d expected entries left unchecked, required 0", exp_q.size());
    end
    @(posedge CP);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
